mac_tx_arbiter: RTL and testbench
=================================

Name: mac_tx_arbiter

Overview:
- Shares the MAC user TX interface (Tx_mac_wa/wr/data/BE/sop/eop) between NUM_REQ packet sources in the clk_user domain.
- Grants are packet-granular and round-robin. A granted source owns the MAC until its eop beat is accepted.
- Sits between the user-side packet generators/DMA engines and MAC_top. Applies flow control from Tx_mac_wa and enforces a programmable idle gap between packets.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- IPG_CYCLES, 2: idle clk_user cycles forced after every eop before the next grant (0..15).
- DATA_W, 32: data word width; fixed by the MAC.

Ports:
- clk_user  in  1  user clock, same as MAC Clk_user
- reset_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  per-source beat valid
- req_data  in  NUM_REQ*DATA_W  per-source data, source i at [i*32 +: 32]
- req_be  in  NUM_REQ*2  per-source byte enable, MAC encoding: 00=4 bytes, 01=1, 10=2, 11=3; meaningful on eop only
- req_sop  in  NUM_REQ  per-source first beat of packet
- req_eop  in  NUM_REQ  per-source last beat of packet
- req_rdy  out  NUM_REQ  per-source beat accepted when vld&rdy
- grant  out  NUM_REQ  one-hot current owner; 0 when idle
- tx_mac_wa  in  1  MAC FIFO can accept; deasserts with at least 2 words of slack
- tx_mac_wr  out  1  MAC write strobe
- tx_mac_data  out  32  MAC data
- tx_mac_be  out  2  MAC byte enable
- tx_mac_sop  out  1  MAC start of packet
- tx_mac_eop  out  1  MAC end of packet
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, grant=0, req_rdy=0, tx_mac_wr=0, tx_mac_data=0, tx_mac_be=0, tx_mac_sop=0, tx_mac_eop=0, gap counter=0, RR pointer=0 (requester 0 has highest priority first).

FSM states:
- IDLE: when any req_vld is high, select the first requester at or after ptr in circular order, with req_vld high. Load grant one-hot and go to XFER. No beat is accepted in the selection cycle.
- XFER: req_rdy[g] = tx_mac_wa; all other rdy bits are 0. A beat is accepted when req_vld[g] & tx_mac_wa. On an accepted beat with req_eop high: ptr = g+1 mod NUM_REQ; grant cleared next cycle. The next state is GAP if IPG_CYCLES>0, else IDLE.
- GAP: count IPG_CYCLES cycles with rdy=0, then go to IDLE.

Output path:
- Fully registered.
- An accepted beat appears on tx_mac_* one cycle later with tx_mac_wr=1. tx_mac_wr=0 otherwise; data, BE, sop and eop hold their last values when wr=0.
- Latency from req beat to MAC write: 1 cycle.
- Minimum grant-to-first-beat: 1 cycle.
- Back-to-back packets from different sources are separated by IPG_CYCLES+1 idle cycles on tx_mac_wr.

Flow control:
- Dropping tx_mac_wa stalls req_rdy in the same cycle (combinational from wa).
- A beat already registered is still written. This relies on the MAC's wa slack.

Framing sanitisation:
- The first accepted beat of a grant is always forwarded with tx_mac_sop=1, whatever req_sop says.
- req_sop on later beats is masked to 0.
- tx_mac_be is forwarded as-is on eop beats and forced to 00 on non-eop beats.

Boundary cases:
- A single-beat packet (sop&eop on the same beat) is legal.
- A source with no other requesters present is re-granted after the gap.
- A requester that drops req_vld mid-packet keeps the grant; no timeout.
- Reset mid-packet clears all outputs immediately; the MAC sees a truncated packet, which is acceptable.
- An eop beat and a new req_vld in the same cycle: the new request is evaluated only in IDLE.

Optional Feature:
- Macro: MAC_TX_ARB_STAT_EN.
- When defined:
  - Adds output pkt_cnt (NUM_REQ*16): per-source count of forwarded eop beats. Counters wrap at 16'hFFFF->0 and reset to 0.
  - Adds output stall_cnt (16): saturating count of XFER cycles with req_vld[g]=1 and tx_mac_wa=0.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package mac_tx_arb_pkg:
  - typedef enum {IDLE, XFER, GAP} arb_state_t.
  - BE encoding constants BE_4B=2'b00, BE_1B=2'b01, BE_2B=2'b10, BE_3B=2'b11.
  - DATA_W constant.
- Sub-module rr_pick: combinational circular priority picker (req vector, ptr) -> one-hot plus index. Instantiated once.

Test Plan:
- Single source 0, 20-beat packet, wa=1 -> grant=4'b0001 one cycle after vld; 20 tx_mac_wr pulses, first with sop=1, last with eop=1 and BE equal to the input (e.g. 2'b10); other beats BE=00.
- All 4 sources request continuously, 3-beat packets each, IPG_CYCLES=2 -> grant order 0,1,2,3,0; exactly 3 idle wr cycles between packets.
- tx_mac_wa toggled 0 for 5 cycles mid-packet -> req_rdy low exactly while wa=0; no wr issued more than 1 cycle after wa falls; data order intact.
- Source 2 sends a first beat with req_sop=0 and a third beat with req_sop=1 -> MAC sees sop=1 on beat 1 only.
- reset_n asserted on beat 4 of an 8-beat packet -> next edge all outputs 0, grant=0; after release, source 0 is granted first.
- MAC_TX_ARB_STAT_EN: 3 packets from source 1 -> pkt_cnt[31:16]=3; preload-style test of 65537 single-beat packets -> count wraps to 1.

Source files
------------

// File: rtl/mac_tx_arb_pkg.sv
// Shared types and constants for the MAC TX arbiter.
package mac_tx_arb_pkg;

  // Data word width, fixed by the MAC user TX interface.
  localparam int DATA_W = 32;

  // MAC byte-enable encoding for the last word of a packet.
  localparam logic [1:0] BE_4B = 2'b00;
  localparam logic [1:0] BE_1B = 2'b01;
  localparam logic [1:0] BE_2B = 2'b10;
  localparam logic [1:0] BE_3B = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mac_tx_arbiter_rr_pick.sv
// Combinational circular priority picker: returns the first asserted
// request at or after ptr_i, as a one-hot vector and as an index.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;

  // Walk the requesters in circular order starting at the pointer.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[(int'(ptr_i) + k) % N]) begin
        found                        = 1'b1;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o                        = IDX_W'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the MAC user TX interface
// between NUM_REQ sources, with flow control from tx_mac_wa and a forced
// idle gap of IPG_CYCLES after every packet.
// Optional statistics counters (pkt_cnt, stall_cnt) are built when the
// macro MAC_TX_ARB_STAT_EN is defined.
module mac_tx_arbiter
  import mac_tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int IPG_CYCLES = 2
) (
  input  logic                      clk_user,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_be,
  input  logic [NUM_REQ-1:0]        req_sop,
  input  logic [NUM_REQ-1:0]        req_eop,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      tx_mac_wa,
  output logic                      tx_mac_wr,
  output logic [DATA_W-1:0]         tx_mac_data,
  output logic [1:0]                tx_mac_be,
  output logic                      tx_mac_sop,
  output logic                      tx_mac_eop,
  output logic                      busy
`ifdef MAC_TX_ARB_STAT_EN
  ,
  output logic [NUM_REQ*16-1:0]     pkt_cnt,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int         IDX_W    = $clog2(NUM_REQ);
  localparam logic [3:0] GAP_LAST = (IPG_CYCLES > 0) ? 4'(IPG_CYCLES - 1) : 4'd0;

  arb_state_t          state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [3:0]          gap_q;
  logic                first_q;
  logic                wr_q;
  logic [DATA_W-1:0]   data_q;
  logic [1:0]          be_q;
  logic                sop_q;
  logic                eop_q;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                sel_vld;
  logic [DATA_W-1:0]   sel_data;
  logic [1:0]          sel_be;
  logic                sel_eop;
  logic                beat_acc;
  logic [IDX_W-1:0]    ptr_d;

  // Framing is regenerated from grant position, so the source's own sop
  // flags never reach the MAC.
  logic unused_sop;
  assign unused_sop = ^req_sop;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i (req_vld),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // Select the granted source's beat signals.
  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    sel_be   = BE_4B;
    sel_eop  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        sel_vld  = req_vld[i];
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_be   = req_be[i*2 +: 2];
        sel_eop  = req_eop[i];
      end
    end
  end

  // Ready follows wa in the same cycle so a stall needs no extra latency.
  assign req_rdy  = (state_q == XFER && tx_mac_wa) ? grant_q : '0;
  assign beat_acc = (state_q == XFER) && sel_vld && tx_mac_wa;
  assign ptr_d    = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

  // Arbitration FSM with registered MAC-side outputs.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the output data registers are reset too, so the MAC never sees X after reset.
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      first_q <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      be_q    <= BE_4B;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples pre-edge values.
      wr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req_vld) begin
            grant_q <= pick_gnt;
            gidx_q  <= pick_idx;
            first_q <= 1'b1;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (beat_acc) begin
            wr_q    <= 1'b1;
            data_q  <= sel_data;
            sop_q   <= first_q;
            first_q <= 1'b0;
            eop_q   <= sel_eop;
            be_q    <= sel_eop ? sel_be : BE_4B;
            if (sel_eop) begin
              ptr_q   <= ptr_d;
              grant_q <= '0;
              gap_q   <= '0;
              state_q <= (IPG_CYCLES > 0) ? GAP : IDLE;
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign tx_mac_wr   = wr_q;
  assign tx_mac_data = data_q;
  assign tx_mac_be   = be_q;
  assign tx_mac_sop  = sop_q;
  assign tx_mac_eop  = eop_q;
  assign busy        = (state_q != IDLE);

`ifdef MAC_TX_ARB_STAT_EN
  logic [NUM_REQ*16-1:0] pkt_cnt_q;
  logic [15:0]           stall_q;

  // Per-source wrapping packet counters and a saturating stall counter.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      if (beat_acc && sel_eop) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (gidx_q == IDX_W'(i)) begin
            pkt_cnt_q[i*16 +: 16] <= pkt_cnt_q[i*16 +: 16] + 16'd1;
          end
        end
      end
      if (state_q == XFER && sel_vld && !tx_mac_wa && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Self-checking bench for mac_tx_arbiter: a packet-level round-robin model
// predicts grant order and the sanitised MAC beat stream; a single compare
// process checks the DUT every cycle, plus directed literal checks.
module tb_mac_tx_arbiter;
  import mac_tx_arb_pkg::*;

  localparam int N   = 4;
  localparam int IPG = 2;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  be;
    logic        sop;
    logic        eop;
  } beat_t;

  logic                clk_user = 1'b0;
  logic                reset_n;
  logic [N-1:0]        req_vld;
  logic [N*DATA_W-1:0] req_data;
  logic [N*2-1:0]      req_be;
  logic [N-1:0]        req_sop;
  logic [N-1:0]        req_eop;
  logic [N-1:0]        req_rdy;
  logic [N-1:0]        grant;
  logic                tx_mac_wa;
  logic                tx_mac_wr;
  logic [DATA_W-1:0]   tx_mac_data;
  logic [1:0]          tx_mac_be;
  logic                tx_mac_sop;
  logic                tx_mac_eop;
  logic                busy;
`ifdef MAC_TX_ARB_STAT_EN
  logic [N*16-1:0]     pkt_cnt;
  logic [15:0]         stall_cnt;
`endif

  mac_tx_arbiter #(.NUM_REQ(N), .IPG_CYCLES(IPG)) dut (
    .clk_user    (clk_user),
    .reset_n     (reset_n),
    .req_vld     (req_vld),
    .req_data    (req_data),
    .req_be      (req_be),
    .req_sop     (req_sop),
    .req_eop     (req_eop),
    .req_rdy     (req_rdy),
    .grant       (grant),
    .tx_mac_wa   (tx_mac_wa),
    .tx_mac_wr   (tx_mac_wr),
    .tx_mac_data (tx_mac_data),
    .tx_mac_be   (tx_mac_be),
    .tx_mac_sop  (tx_mac_sop),
    .tx_mac_eop  (tx_mac_eop),
    .busy        (busy)
`ifdef MAC_TX_ARB_STAT_EN
    ,
    .pkt_cnt     (pkt_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk_user = ~clk_user;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_user) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus queues (driver side) and model queues (packet-level reference).
  beat_t src_q [N][$];
  beat_t m_q   [N][$];
  beat_t exp_q [$];
  int    exp_grant [$];
  int    m_ptr = 0;

  // Observation state kept by the compare process.
  bit    chk_en = 1'b0;
  logic  wa_prev = 1'b1;
  logic [N-1:0] prev_grant = '0;
  int    wr_count = 0;
  int    sop_count = 0;
  int    grant_log [$];
  int    gaps [$];
  int    last_eop_cyc = 0;
  bit    eop_seen = 1'b0;
  logic [1:0] last_be = 2'b00;
  int    grant_cyc = 0;
  int    first_vld_cyc = 0;

  task automatic add_pkt(input int s, input int n, input logic [31:0] base,
                         input logic [1:0] be, input logic [31:0] sop_mask);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 32'(k);
      b.be   = be;
      b.sop  = sop_mask[k];
      b.eop  = (k == n - 1);
      src_q[s].push_back(b);
      m_q[s].push_back(b);
    end
  endtask

  // Packet-level round robin: serve whole packets, next source after the last served.
  task automatic plan();
    beat_t b;
    beat_t e;
    bit    any;
    int    s;
    bit    first;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      s   = 0;
      for (int k = 0; k < N; k++) begin
        if (!any && m_q[(m_ptr + k) % N].size() > 0) begin
          any = 1'b1;
          s   = (m_ptr + k) % N;
        end
      end
      if (any) begin
        exp_grant.push_back(s);
        first = 1'b1;
        do begin
          b      = m_q[s].pop_front();
          e.data = b.data;
          e.sop  = first;
          e.eop  = b.eop;
          e.be   = b.eop ? b.be : 2'b00;
          exp_q.push_back(e);
          first  = 1'b0;
        end while (!b.eop);
        m_ptr = (s + 1) % N;
      end
    end
  endtask

  function automatic bit src_empty();
    bit r = 1'b1;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) r = 1'b0;
    return r;
  endfunction

  // Driver: present each source's head beat; pop it once a handshake was seen.
  initial begin
    logic [N-1:0] fired;
    logic [N-1:0] pv;
    req_vld  = '0;
    req_data = '0;
    req_be   = '0;
    req_sop  = '0;
    req_eop  = '0;
    forever begin
      @(negedge clk_user);
      fired = req_vld & req_rdy;
      @(posedge clk_user);
      #1;
      pv = req_vld;
      for (int i = 0; i < N; i++) begin
        if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_vld[i]             = 1'b1;
          req_data[i*32 +: 32]   = src_q[i][0].data;
          req_be[i*2 +: 2]       = src_q[i][0].be;
          req_sop[i]             = src_q[i][0].sop;
          req_eop[i]             = src_q[i][0].eop;
        end else begin
          req_vld[i] = 1'b0;
          req_sop[i] = 1'b0;
          req_eop[i] = 1'b0;
        end
      end
      if (pv == '0 && req_vld != '0) first_vld_cyc = cyc;
    end
  end

  // Compare process: checks DUT outputs against the model every cycle.
  always @(negedge clk_user) begin
    beat_t e;
    logic [N-1:0] eg;
    int gi;
    if (reset_n && chk_en) begin
      check("rdy_rule", 64'(req_rdy), 64'(tx_mac_wa ? grant : '0));
      check("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
      if (grant != '0) check("busy_when_granted", 64'(busy), 64'd1);
      if (tx_mac_wr) begin
        check("wr_needs_wa", 64'(wa_prev), 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("mac_beat", {28'h0, tx_mac_data, tx_mac_be, tx_mac_sop, tx_mac_eop},
                            {28'h0, e.data, e.be, e.sop, e.eop});
        end
        wr_count++;
        if (tx_mac_sop) begin
          sop_count++;
          if (eop_seen) gaps.push_back(cyc - last_eop_cyc - 1);
        end
        if (tx_mac_eop) begin
          last_eop_cyc = cyc;
          eop_seen     = 1'b1;
          last_be      = tx_mac_be;
        end
      end
      if (grant != '0 && prev_grant == '0) begin
        gi = 0;
        for (int i = 0; i < N; i++) if (grant[i]) gi = i;
        grant_log.push_back(gi);
        grant_cyc = cyc;
        if (exp_grant.size() == 0) begin
          check("unexpected_grant", 64'(grant), 64'd0);
        end else begin
          eg = '0;
          eg[exp_grant.pop_front()] = 1'b1;
          check("grant_order", 64'(grant), 64'(eg));
        end
      end
      prev_grant = grant;
      wa_prev    = tx_mac_wa;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_wr"},    64'(tx_mac_wr),   64'd0);
    check({tag, "_data"},  64'(tx_mac_data), 64'd0);
    check({tag, "_be"},    64'(tx_mac_be),   64'd0);
    check({tag, "_sop"},   64'(tx_mac_sop),  64'd0);
    check({tag, "_eop"},   64'(tx_mac_eop),  64'd0);
    check({tag, "_grant"}, 64'(grant),       64'd0);
    check({tag, "_rdy"},   64'(req_rdy),     64'd0);
    check({tag, "_busy"},  64'(busy),        64'd0);
  endtask

  task automatic do_reset(input bit chk, input string tag);
    @(posedge clk_user);
    #3;
    reset_n = 1'b0;
    chk_en  = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      m_q[i].delete();
    end
    exp_q.delete();
    exp_grant.delete();
    m_ptr = 0;
    @(negedge clk_user);
    if (chk) check_zero(tag);
    @(posedge clk_user);
    #3;
    reset_n    = 1'b1;
    prev_grant = '0;
    eop_seen   = 1'b0;
    wa_prev    = tx_mac_wa;
    grant_log.delete();
    gaps.delete();
    chk_en     = 1'b1;
    @(negedge clk_user);
    #2;
  endtask

  task automatic wait_done(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk_user);
      if (exp_q.size() == 0 && exp_grant.size() == 0 && src_empty()) done = 1'b1;
    end
    check({tag, "_drain_timeout"}, 64'(done), 64'd1);
    repeat (IPG + 3) @(negedge clk_user);
    #2;
  endtask

  task automatic wait_wr(input int target, input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk_user);
      if (wr_count >= target) done = 1'b1;
    end
    check({tag, "_wr_timeout"}, 64'(done), 64'd1);
  endtask

  initial begin
    int w0;
    int s0;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    reset_n   = 1'b0;
    tx_mac_wa = 1'b1;

    // Reset values.
    @(negedge clk_user);
    check_zero("reset");
    @(posedge clk_user);
    #3;
    reset_n = 1'b1;
    wa_prev = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk_user);
    #2;

    // Single source 0, 20-beat packet, eop BE 2'b10.
    w0 = wr_count;
    add_pkt(0, 20, 32'hA000_0000, 2'b10, 32'h1);
    plan();
    wait_done("t1");
    check("t1_wr_pulses", 64'(wr_count - w0), 64'd20);
    check("t1_grant_latency", 64'(grant_cyc - first_vld_cyc), 64'd1);
    check("t1_grant_src", 64'(grant_log[$]), 64'd0);
    check("t1_last_be", 64'(last_be), 64'(2'b10));

    // All sources, 3-beat packets, round-robin order and idle gaps.
    do_reset(1'b0, "t2");
    add_pkt(0, 3, 32'hB000_0000, 2'b01, 32'h1);
    add_pkt(0, 3, 32'hB000_0100, 2'b11, 32'h1);
    add_pkt(1, 3, 32'hB100_0000, 2'b10, 32'h1);
    add_pkt(2, 3, 32'hB200_0000, 2'b00, 32'h1);
    add_pkt(3, 3, 32'hB300_0000, 2'b01, 32'h1);
    plan();
    wait_done("t2");
    check("t2_grant_count", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check("t2_grant_seq", 64'(grant_log[i]), 64'(exp_order[i]));
    check("t2_gap_count", 64'(gaps.size()), 64'd4);
    for (int i = 0; i < gaps.size(); i++)
      check("t2_idle_gap", 64'(gaps[i]), 64'(IPG + 1));

    // wa dropped for 5 cycles in the middle of a 12-beat packet.
    w0 = wr_count;
    add_pkt(1, 12, 32'hC100_0000, 2'b01, 32'h1);
    plan();
    wait_wr(w0 + 4, "t3");
    @(posedge clk_user);
    #1;
    tx_mac_wa = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_user);
      check("t3_rdy_stall", 64'(req_rdy), 64'd0);
      if (k > 0) check("t3_no_late_wr", 64'(tx_mac_wr), 64'd0);
      @(posedge clk_user);
    end
    #1;
    tx_mac_wa = 1'b1;
    wait_done("t3");
    check("t3_wr_pulses", 64'(wr_count - w0), 64'd12);

    // Source 2: req_sop only on the third beat; MAC sop only on the first.
    s0 = sop_count;
    add_pkt(2, 3, 32'hD200_0000, 2'b11, 32'h4);
    plan();
    wait_done("t4");
    check("t4_sop_count", 64'(sop_count - s0), 64'd1);

    // Reset on beat 4 of an 8-beat packet from source 3.
    w0 = wr_count;
    add_pkt(3, 8, 32'hE300_0000, 2'b10, 32'h1);
    plan();
    wait_wr(w0 + 4, "t5");
    do_reset(1'b1, "t5_midpkt");
    add_pkt(3, 2, 32'hE310_0000, 2'b01, 32'h1);
    add_pkt(0, 2, 32'hE000_0000, 2'b01, 32'h1);
    plan();
    wait_done("t5");
    check("t5_grant_count", 64'(grant_log.size()), 64'd2);
    check("t5_first_grant", 64'(grant_log[0]), 64'd0);

`ifdef MAC_TX_ARB_STAT_EN
    // Statistics: three packets from source 1.
    do_reset(1'b0, "t6");
    for (int p = 0; p < 3; p++) add_pkt(1, 2, 32'hF100_0000 + 32'(p * 16), 2'b00, 32'h1);
    plan();
    wait_done("t6");
    check("t6_pkt_cnt1", 64'(pkt_cnt[31:16]), 64'd3);
    check("t6_pkt_cnt0", 64'(pkt_cnt[15:0]), 64'd0);
    check("t6_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
